// File: rtl/multicycle_control.sv
// Sequencing FSM for the multi-cycle RV32I core: fetch/decode/execute/memory/writeback.
// Latency: 3 (branch/jump), 4 (ALU ops, store), 5 (load) cycles with zero-wait memory.
// Memory waits on mem_ready; a stall longer than MEM_TIMEOUT cycles traps with bus_error.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       alu_sub_en,
  output logic [1:0] result_src,
  output logic       instr_retired,
  output logic       illegal,
  output logic       bus_error,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_JAL    = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Counter is compared one bit wider so the increment never wraps before the compare.
  localparam logic [TO_W:0] LP_LIMIT = MEM_TIMEOUT[TO_W:0];
  localparam bit            LP_TO_EN = (MEM_TIMEOUT != 0);

  state_t          r_state;
  state_t          w_next;
  logic [TO_W-1:0] r_cnt;
  logic [TO_W:0]   w_cnt_inc;
  logic            w_waiting;
  logic            w_timeout;
  logic            w_set_illegal;
  logic            w_set_bus_err;
  logic            r_illegal;
  logic            r_bus_error;

  // A memory-facing state that has not yet seen mem_ready is a wait cycle.
  assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR))
                     && !mem_ready;
  assign w_cnt_inc = {1'b0, r_cnt} + {{TO_W{1'b0}}, 1'b1};
  // Trap on the wait cycle that brings the count up to the limit.
  assign w_timeout = LP_TO_EN && w_waiting && (w_cnt_inc == LP_LIMIT);

  assign illegal   = r_illegal;
  assign bus_error = r_bus_error;
  assign state_out = r_state;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Wait counter: restarts on every state change, counts stalled memory cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if (w_waiting) begin
      r_cnt <= w_cnt_inc[TO_W-1:0];
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_illegal   <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      if (w_set_illegal) r_illegal   <= 1'b1;
      if (w_set_bus_err) r_bus_error <= 1'b1;
    end
  end

  // Next-state and datapath controls, decoded from the current state.
  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    w_set_bus_err = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    alu_sub_en    = 1'b0;
    result_src    = 2'b00;
    instr_retired = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end else if (w_timeout) begin
          w_set_bus_err = 1'b1;
          w_next        = S_TRAP;
        end
      end
      S_DECODE: begin
        // Precompute the branch/jump target into ALUOut.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        case (opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXEC_R;
          OP_ITYPE:          w_next = S_EXEC_I;
          OP_JAL:            w_next = S_JAL;
          OP_BRANCH: begin
            if (funct3 == 3'b000) begin
              w_next = S_BEQ;
            end else begin
              w_set_illegal = 1'b1;
              w_next        = S_TRAP;
            end
          end
          default: begin
            w_set_illegal = 1'b1;
            w_next        = S_TRAP;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        w_next    = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          w_next = S_MEMWB;
        end else if (w_timeout) begin
          w_set_bus_err = 1'b1;
          w_next        = S_TRAP;
        end
      end
      S_MEMWB: begin
        reg_write     = 1'b1;
        result_src    = 2'b01;
        instr_retired = 1'b1;
        w_next        = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          instr_retired = 1'b1;
          w_next        = S_FETCH;
        end else if (w_timeout) begin
          w_set_bus_err = 1'b1;
          w_next        = S_TRAP;
        end
      end
      S_EXEC_R: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b00;
        alu_op     = 2'b10;
        alu_sub_en = 1'b1;
        w_next     = S_ALUWB;
      end
      S_EXEC_I: begin
        // instruction[30] is immediate data here, so sub must stay gated off.
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        w_next        = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a     = 2'b10;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_src        = 1'b1;
        instr_retired = 1'b1;
        w_next        = S_FETCH;
      end
      S_JAL: begin
        // ALU forms oldPC+4 for rd while the PC loads the target held in ALUOut.
        alu_src_a     = 2'b01;
        alu_src_b     = 2'b01;
        result_src    = 2'b10;
        reg_write     = 1'b1;
        pc_write      = 1'b1;
        pc_src        = 1'b1;
        instr_retired = 1'b1;
        w_next        = S_FETCH;
      end
      S_TRAP: begin
        w_next = S_TRAP;
      end
      default: begin
        w_next = S_TRAP;
      end
    endcase
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main sequencing FSM for the multi-cycle RV32I core variant; replaces the single-cycle opcode decoder.
- Steps each instruction through fetch/decode/execute/memory/writeback, sharing one ALU for PC increment, branch target, address and result.
- Drives datapath mux selects, register/memory/PC write enables, and the 2-bit ALU-op code consumed by the existing ALU-control decoder (00 add, 01 sub, 10 funct-decoded).
- Handles variable-latency memory through a ready handshake with timeout.

Parameters:
MEM_TIMEOUT, 255, max cycles to wait for mem_ready in one memory state; 0 disables timeout
TO_W, 8, width of timeout counter; MEM_TIMEOUT must fit in TO_W bits

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces FETCH
opcode  in  7  instruction[6:0] from instruction register
funct3  in  3  instruction[14:12]
mem_ready  in  1  memory completes current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
pc_src  out  1  PC mux: 0 ALU result, 1 ALUOut register
iord  out  1  memory address: 0 PC, 1 ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  instruction register load
reg_write  out  1  register file write
alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1
alu_src_b  out  2  00 rs2, 01 constant 4, 10 immediate
alu_op  out  2  to ALU-control decoder
alu_sub_en  out  1  gate on instruction[30] into the decoder; 1 only in EXEC_R
result_src  out  2  writeback: 00 ALUOut, 01 MDR, 10 ALU result
instr_retired  out  1  one-cycle pulse on instruction completion
illegal  out  1  sticky, unsupported opcode/funct3
bus_error  out  1  sticky, memory timeout
state_out  out  4  current state encoding, debug

Behaviour:
- States/encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC_R 6, EXEC_I 7, ALUWB 8, BEQ 9, JAL 10, TRAP 11.
- State, illegal, bus_error, timeout counter are registers. All other outputs are combinational from state (plus mem_ready where stated). Unlisted outputs are 0 in every state.
- Reset (async, any time, including mid memory access): state=FETCH, illegal=0, bus_error=0, counter=0. Outputs immediately take FETCH values: mem_read=1, alu_src_b=01, all else 0. An in-flight mem_write drops immediately.
- FETCH: mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00, pc_src=0. When mem_ready=1: ir_write=1, pc_write=1, next DECODE; else hold.
- DECODE: alu_src_a=01, alu_src_b=10, alu_op=00 (branch/jump target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 with funct3=000 -> BEQ
  - 1101111 -> JAL
  - anything else (including 1100011 with funct3 != 000) -> TRAP, illegal set on entry.
- MEMADR: alu_src_a=10, alu_src_b=10, alu_op=00. Load -> MEMRD; store -> MEMWR.
- MEMRD: iord=1, mem_read=1. On mem_ready -> MEMWB.
- MEMWB: reg_write=1, result_src=01, instr_retired=1 -> FETCH.
- MEMWR: iord=1, mem_write=1. On mem_ready: instr_retired=1, then FETCH.
- EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10, alu_sub_en=1 -> ALUWB.
- EXEC_I: alu_src_a=10, alu_src_b=10, alu_op=10, alu_sub_en=0 (addi with imm[10]=1 must add) -> ALUWB.
- ALUWB: reg_write=1, result_src=00, instr_retired=1 -> FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=1, instr_retired=1 -> FETCH.
- JAL: alu_src_a=01, alu_src_b=01, alu_op=00, result_src=10, reg_write=1, pc_write=1, pc_src=1, instr_retired=1 -> FETCH. This writes oldPC+4 to rd and loads the target from ALUOut.
- Timeout: counter clears on entry to FETCH/MEMRD/MEMWR and increments each cycle in those states while mem_ready=0. If the counter reaches MEM_TIMEOUT with mem_ready still 0 (MEM_TIMEOUT != 0) -> TRAP, bus_error set. mem_ready=1 in the same cycle as the limit wins (normal transition).
- TRAP: all enables 0, mem_read=0; held until reset. illegal/bus_error clear only on reset.
- Latency with mem_ready=1 on first request cycle:
  - R/I-type, BEQ, JAL: 4/4/3/3 cycles
  - load: 5 cycles
  - store: 4 cycles

Test Plan:
- Reset asserted for 3 cycles mid-MEMWR, mem_ready=0 -> mem_write falls asynchronously; state_out=0, mem_read=1 after release.
- add (0110011) with mem_ready tied 1 -> states 0,1,6,8; alu_op=10 and alu_sub_en=1 in state 6; reg_write and instr_retired pulse in state 8; 4 cycles.
- lw with mem_ready delayed 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with result_src=01; total 8 cycles.
- Branch opcode with funct3=001 -> TRAP; illegal=1; pc_write, reg_write, mem_* stay 0 for 20 cycles; instr_retired never pulses.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP entered after the 4th wait cycle, bus_error=1; with MEM_TIMEOUT=0 the FSM waits indefinitely.
- jal then addi with imm bit 10 set -> JAL state asserts pc_write, pc_src=1, result_src=10; EXEC_I has alu_sub_en=0.
